// File: rtl/mgt_01_divide_unit_pkg.sv
// Shared types and constants for the sequential RV32M divide unit.
// Holds the op codes, the issue-facing FU state and the divider FSM encoding.
package mgt_01_divide_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {DIV_, DIVU_, REM_, REMU_} div_ops_e;
  typedef enum logic       {FREE, BUSY}               fu_state_e;
  typedef enum logic [1:0] {IDLE, DIVIDE, FINALIZE}   div_fsm_e;

  localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XLEN - 1);

  function automatic logic is_signed_op(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  // One extra bit so that the magnitude of the most negative value is exact.
  function automatic logic [XLEN:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
    logic [XLEN:0] ext;
    ext = {sgn & x[XLEN-1], x};
    return (sgn && x[XLEN-1]) ? -ext : ext;
  endfunction

endpackage

// File: rtl/mgt_01_divide_unit_if.sv
// Issue/result interface of the divide unit.
// master = issue logic side, slave = the functional unit itself.
interface mgt_01_divide_unit_if
  import mgt_01_divide_unit_pkg::*;
  ();

  logic            valid_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  div_ops_e        operation_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  fu_state_e       fu_state_o;
  logic            sel_mux_o;

  modport master (
    output valid_i, dividend_i, divisor_i, operation_i,
    input  result_o, valid_o, fu_state_o, sel_mux_o
  );

  modport slave (
    input  valid_i, dividend_i, divisor_i, operation_i,
    output result_o, valid_o, fu_state_o, sel_mux_o
  );

endinterface

// File: rtl/mgt_01_divide_unit_div_step.sv
// One combinational restoring-division iteration on operand magnitudes.
// Chain two of these for a radix-4 variant.
module mgt_01_div_step
  import mgt_01_divide_unit_pkg::*;
(
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN:0]   i_dmag,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_ge;

  always_comb begin
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, i_dmag});
    w_trial = w_shift[XLEN:0] - i_dmag;
    o_rem   = w_ge ? w_trial : w_shift[XLEN:0];
    o_quo   = {i_quo[XLEN-2:0], w_ge};
  end

endmodule

// File: rtl/mgt_01_divide_unit.sv
// Non-pipelined radix-2 restoring divider/remainder unit (DIV/DIVU/REM/REMU).
// state    | meaning
// IDLE     | FREE; accept request, detect div-by-zero / signed overflow
// DIVIDE   | one restoring iteration per enabled cycle, 32 total
// FINALIZE | sign-correct, register result, pulse valid_o
module mgt_01_divide_unit
  import mgt_01_divide_unit_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  mgt_01_divide_unit_if.slave  bus
);

  div_fsm_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN:0]   r_div_mag;
  div_ops_e        r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  fu_state_e       r_fu_state;

  logic            w_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN:0]   w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN:0]   w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic            w_is_div;

  always_comb begin
    w_sgn      = is_signed_op(bus.operation_i);
    w_a_neg    = w_sgn & bus.dividend_i[XLEN-1];
    w_b_neg    = w_sgn & bus.divisor_i[XLEN-1];
    // 0x8000_0000 negates to itself, which is already the correct unsigned magnitude.
    w_a_mag    = w_a_neg ? -bus.dividend_i : bus.dividend_i;
    w_b_mag    = magnitude(bus.divisor_i, w_sgn);
    w_div_zero = (bus.divisor_i == '0);
    w_ovf      = w_sgn && (bus.dividend_i == SIGNED_MIN) && (bus.divisor_i == '1);
    w_q        = r_neg_q ? -r_quo : r_quo;
    w_r        = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    w_is_div   = (r_op == DIV_) || (r_op == DIVU_);
  end

  mgt_01_div_step u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dmag (r_div_mag),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div_mag  <= '0;
      r_op       <= DIV_;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_fu_state <= FREE;
    end else if (clk_en_i) begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (bus.valid_i) begin
            r_op       <= bus.operation_i;
            r_div_mag  <= w_b_mag;
            r_cnt      <= '0;
            r_fu_state <= BUSY;
            // Special cases preload the final quotient/remainder and skip the iterations.
            if (w_div_zero) begin
              r_quo   <= '1;
              r_rem   <= {1'b0, bus.dividend_i};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= FINALIZE;
            end else if (w_ovf) begin
              r_quo   <= SIGNED_MIN;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= FINALIZE;
            end else begin
              r_quo   <= w_a_mag;
              r_rem   <= '0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= FINALIZE;
        end
        FINALIZE: begin
          r_result   <= w_is_div ? w_q : w_r;
          r_valid    <= 1'b1;
          r_fu_state <= FREE;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result_o   = r_result;
  assign bus.valid_o    = r_valid;
  assign bus.sel_mux_o  = r_valid;
  assign bus.fu_state_o = r_fu_state;

endmodule

// File: tb/tb_mgt_01_divide_unit.sv
// Directed bench for the divide unit; latency counts the accept edge as cycle 1
// and the edge that raises valid_o as the last cycle.
module tb_mgt_01_divide_unit;
  import mgt_01_divide_unit_pkg::*;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   checks;
  int   failures;

  mgt_01_divide_unit_if bus ();

  mgt_01_divide_unit dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input div_ops_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0)
      return (op == DIV_ || op == DIVU_) ? 32'hFFFF_FFFF : a;
    if ((op == DIV_ || op == REM_) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV_) ? 32'h8000_0000 : 32'h0;
    case (op)
      DIV_:    return sa / sb;
      REM_:    return sa % sb;
      DIVU_:   return a / b;
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge with the unit FREE; returns at the negedge where valid_o is high.
  task automatic run_op(input string tag, input div_ops_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit stall);
    int lat;
    bit got;
    got = 1'b0;
    bus.valid_i     = 1'b1;
    bus.operation_i = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    @(posedge clk);
    lat = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.valid_i    = 1'b0;
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
      end
      if (bus.valid_o) begin
        got = 1'b1;
        break;
      end
      if (stall) begin
        if (lat == 8) begin
          bus.valid_i     = 1'b1;
          bus.operation_i = DIVU_;
          bus.dividend_i  = 32'd50;
          bus.divisor_i   = 32'd1;
        end else begin
          bus.valid_i = 1'b0;
        end
        clk_en = !(lat >= 15 && lat <= 19);
        if (lat == 17) chk({tag, "_busy_in_stall"}, 32'(bus.fu_state_o), 32'(BUSY));
      end
      @(posedge clk);
      lat++;
    end
    clk_en = 1'b1;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout observed=no_valid expected=valid_within_200", tag);
    end else begin
      chk({tag, "_result"}, bus.result_o, exp);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_sel_mux"}, 32'(bus.sel_mux_o), 32'd1);
      chk({tag, "_fu_free"}, 32'(bus.fu_state_o), 32'(FREE));
    end
  endtask

  initial begin
    int pulses;
    div_ops_e    rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    bit          special;

    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    clk_en          = 1'b1;
    bus.valid_i     = 1'b0;
    bus.operation_i = DIV_;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_sel_mux", 32'(bus.sel_mux_o), 32'd0);
    chk("rst_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", DIVU_, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    // back-to-back: valid_o must be a single-cycle pulse
    run_op("remu_100_7", REMU_, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op("div_m7_2", DIV_, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_m7_2", REM_, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("div_7_m2", DIV_, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("div_5_0", DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("rem_5_0", REM_, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    run_op("rem_m7_0", REM_, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, 1'b0);
    run_op("divu_max_0", DIVU_, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("div_ovf", DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem_ovf", REM_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1'b0);
    run_op("divu_min_m1", DIVU_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 1'b0);
    run_op("div_min_2", DIV_, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, 1'b0);

    // valid_o stretches while clk_en is low
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("stretch_valid", 32'(bus.valid_o), 32'd1);
    chk("stretch_result", bus.result_o, 32'hC000_0000);
    clk_en = 1'b1;
    @(negedge clk);
    chk("stretch_release", 32'(bus.valid_o), 32'd0);

    // 5-cycle enable stall mid-divide plus an ignored request while busy
    run_op("divu_stall", DIVU_, 32'd1000, 32'd3, 32'd333, 39, 1'b1);
    pulses = 0;
    @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    chk("dropped_request", 32'(pulses), 32'd0);
    chk("dropped_fu_free", 32'(bus.fu_state_o), 32'(FREE));

    // reset aborts an operation at iteration 10
    bus.valid_i     = 1'b1;
    bus.operation_i = DIVU_;
    bus.dividend_i  = 32'h1234_5678;
    bus.divisor_i   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.fu_state_o), 32'(BUSY));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", bus.result_o, 32'h0);
    chk("abort_valid", 32'(bus.valid_o), 32'd0);
    chk("abort_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    run_op("divu_after_rst", DIVU_, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34, 1'b0);

    // randomized back-to-back operations against a language-level division model
    for (int n = 0; n < 250; n++) begin
      rop = div_ops_e'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = (sel == 9) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'h0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        9:       rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd3;
        default: rb = $urandom;
      endcase
      special = (rb == 32'h0) ||
                ((rop == DIV_ || rop == REM_) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
      run_op("random", rop, ra, rb, ref_result(rop, ra, rb), special ? 2 : 34, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
